// File: rtl/npu_pkg.sv
// Shared definitions for the NPU matrix engine: default widths, FSM state
// encoding and the row-major element-offset helper.
package npu_pkg;

  localparam int N_DEF          = 2;
  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 10;
  localparam int LAUNCH_DLY_DEF = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_MAC   = 3'd4;
  localparam logic [2:0] ST_WB    = 3'd5;
  localparam logic [2:0] ST_ACK   = 3'd6;

  function automatic int elem_off(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/npu_mac.sv
// Multiply-accumulate slice: signed product truncated to DATA_W, accumulator
// restarts from zero on the first term of each dot product.
module npu_mac
  import npu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc_d
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] prod;

  // Low DATA_W bits of a signed product; sum wraps mod 2^DATA_W.
  assign prod = $signed(a) * $signed(b);

  always_comb begin
    acc_d = (clr ? '0 : acc_q) + prod;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/npu_mat_engine.sv
// NPU matrix engine: fetches A and B from data memory, computes C = A x B
// (N x N, row-major) and writes C back, handshaking with ID via busy/ack.
module npu_mat_engine
  import npu_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LAUNCH_DLY = LAUNCH_DLY_DEF
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              en_npu,
  input  logic [ADDR_W-1:0] matA_addr,
  input  logic [ADDR_W-1:0] matB_addr,
  input  logic [ADDR_W-1:0] matC_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              ack
);

  localparam int NN    = N * N;
  localparam int LOADS = 2 * NN;
  localparam int CNT_W = $clog2((LOADS > LAUNCH_DLY) ? LOADS : LAUNCH_DLY) + 1;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LAUNCH_DLY - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOADS - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(N - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  logic              en_prev_q;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [DATA_W-1:0] a_buf_q [NN];
  logic [DATA_W-1:0] a_buf_d [NN];
  logic [DATA_W-1:0] b_buf_q [NN];
  logic [DATA_W-1:0] b_buf_d [NN];
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  pend_idx_q, pend_idx_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d, busy_q, busy_d, ack_q, ack_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] a_op, b_op, acc_d;

  npu_mac #(.DATA_W(DATA_W)) u_mac (
    .clk   (clk_50),
    .rst_n (rst_n),
    .en    (state_q == ST_MAC),
    .clr   (k_q == '0),
    .a     (a_op),
    .b     (b_op),
    .acc_d (acc_d)
  );

  // Read data lands one cycle after its request; the pending tag says where.
  always_comb begin
    a_buf_d    = a_buf_q;
    b_buf_d    = b_buf_q;
    pend_d     = rd_en_q;
    pend_idx_d = cnt_q;
    a_op       = '0;
    b_op       = '0;
    for (int e = 0; e < NN; e++) begin
      if (pend_q && pend_idx_q == CNT_W'(e))      a_buf_d[e] = mem_rd_data;
      if (pend_q && pend_idx_q == CNT_W'(e + NN)) b_buf_d[e] = mem_rd_data;
      if (elem_off(int'(i_q), int'(k_q), N) == e) a_op = a_buf_q[e];
      if (elem_off(int'(k_q), int'(j_q), N) == e) b_op = b_buf_q[e];
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    c_base_d  = c_base_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (en_npu && !en_prev_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (!en_npu) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          a_base_d  = matA_addr;
          b_base_d  = matB_addr;
          c_base_d  = matC_addr;
          rd_en_d   = 1'b1;
          rd_addr_d = matA_addr;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOAD: begin
        if (!en_npu) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LOAD_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d     = cnt_inc;
          rd_en_d   = 1'b1;
          rd_addr_d = (cnt_inc < CNT_W'(NN)) ? a_base_q + ADDR_W'(cnt_inc)
                                             : b_base_q + ADDR_W'(cnt_inc - CNT_W'(NN));
        end
      end
      ST_DRAIN: begin
        state_d = en_npu ? ST_MAC : ST_IDLE;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
      end
      ST_MAC: begin
        if (!en_npu) begin
          state_d = ST_IDLE;
        end else if (k_q == IDX_LAST) begin
          wr_en_d   = 1'b1;
          wr_addr_d = c_base_q + ADDR_W'(elem_off(int'(i_q), int'(j_q), N));
          wr_data_d = acc_d;
          k_d       = '0;
          if (j_q == IDX_LAST) begin
            j_d = '0;
            if (i_q == IDX_LAST) begin
              i_d     = '0;
              state_d = ST_WB;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      ST_WB:   state_d = en_npu ? ST_ACK : ST_IDLE;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    ack_d  = (state_d == ST_ACK);
  end

  // NOTE: the operand buffers are small register arrays, so they take the
  // async reset like any other flop rather than being left uninitialised.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      en_prev_q  <= 1'b0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      for (int e = 0; e < NN; e++) begin
        a_buf_q[e] <= '0;
        b_buf_q[e] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      en_prev_q  <= en_npu;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      c_base_q   <= c_base_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      a_buf_q    <= a_buf_d;
      b_buf_q    <= b_buf_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign ack         = ack_q;

endmodule

// File: tb/tb_npu_mat_engine.sv
// Directed bench for npu_mat_engine: table of 2x2 matrix vectors with
// hand-computed results, plus abort, re-arm and mid-operation reset sequences.
module tb_npu_mat_engine;

  logic        clk_50 = 1'b0;
  logic        rst_n;
  logic        en_npu;
  logic [9:0]  matA_addr, matB_addr, matC_addr;
  logic        mem_rd_en, mem_wr_en, busy, ack;
  logic [9:0]  mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data;

  logic [31:0] mem [1024];
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [9:0]  ra_q[$];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [9:0]  a_addr, b_addr, c_addr;
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] c [4];
    logic [9:0]  rd [8];
    logic [9:0]  wr [4];
  } vec_t;

  vec_t vecs [4];

  npu_mat_engine dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .en_npu      (en_npu),
    .matA_addr   (matA_addr),
    .matB_addr   (matB_addr),
    .matC_addr   (matC_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .ack         (ack)
  );

  always #5 clk_50 = ~clk_50;

  // Synchronous-read memory: data for a request appears after the next edge.
  always @(posedge clk_50) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int vi);
    logic [9:0] ad;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int e = 0; e < 4; e++) begin
      ad = vecs[vi].a_addr + 10'(e);
      mem[ad] = vecs[vi].a[e];
      ad = vecs[vi].b_addr + 10'(e);
      mem[ad] = vecs[vi].b[e];
    end
    matA_addr = vecs[vi].a_addr;
    matB_addr = vecs[vi].b_addr;
    matC_addr = vecs[vi].c_addr;
  endtask

  // Raises en_npu, logs memory traffic until ack or a cycle budget expires.
  task automatic run_vec(input int vi);
    int lat;
    int overlap;
    int restart;
    load_vec(vi);
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    lat     = -1;
    overlap = 0;
    restart = 0;
    @(negedge clk_50);
    en_npu = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_50);
      if (mem_wr_en) begin
        wa_q.push_back(mem_wr_addr);
        wd_q.push_back(mem_wr_data);
      end
      if (mem_rd_en) ra_q.push_back(mem_rd_addr);
      if (mem_rd_en && mem_wr_en) overlap++;
      if (ack) begin
        lat = n - 1;
        break;
      end
    end
    check($sformatf("v%0d_ack_latency", vi), 64'(lat), 64'd22);
    check($sformatf("v%0d_rd_wr_overlap", vi), 64'(overlap), 64'd0);
    check($sformatf("v%0d_rd_count", vi), 64'(ra_q.size()), 64'd8);
    for (int e = 0; e < 8; e++)
      if (e < ra_q.size()) check($sformatf("v%0d_rd_addr%0d", vi, e), 64'(ra_q[e]), 64'(vecs[vi].rd[e]));
    check($sformatf("v%0d_wr_count", vi), 64'(wa_q.size()), 64'd4);
    for (int e = 0; e < 4; e++) begin
      if (e < wa_q.size()) begin
        check($sformatf("v%0d_wr_addr%0d", vi, e), 64'(wa_q[e]), 64'(vecs[vi].wr[e]));
        check($sformatf("v%0d_wr_data%0d", vi, e), 64'(wd_q[e]), 64'(vecs[vi].c[e]));
      end
    end
    @(negedge clk_50);
    check($sformatf("v%0d_post_ack", vi), 64'({ack, busy}), 64'd0);
    // en_npu still high: the engine must not restart on a held level.
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_50);
      if (busy || ack) restart++;
    end
    check($sformatf("v%0d_no_restart", vi), 64'(restart), 64'd0);
    en_npu = 1'b0;
    @(negedge clk_50);
  endtask

  initial begin
    int quiet;

    vecs[0].a_addr = 10'h010; vecs[0].b_addr = 10'h020; vecs[0].c_addr = 10'h030;
    vecs[0].a  = '{32'd1, 32'd0, 32'd0, 32'd1};
    vecs[0].b  = '{32'd5, 32'd6, 32'd7, 32'd8};
    vecs[0].c  = '{32'd5, 32'd6, 32'd7, 32'd8};
    vecs[0].rd = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h020, 10'h021, 10'h022, 10'h023};
    vecs[0].wr = '{10'h030, 10'h031, 10'h032, 10'h033};

    vecs[1].a_addr = 10'h040; vecs[1].b_addr = 10'h050; vecs[1].c_addr = 10'h060;
    vecs[1].a  = '{32'hFFFFFFFF, 32'd2, 32'd3, 32'hFFFFFFFC};
    vecs[1].b  = '{32'd2, 32'd0, 32'd1, 32'hFFFFFFFD};
    vecs[1].c  = '{32'd0, 32'hFFFFFFFA, 32'd2, 32'd12};
    vecs[1].rd = '{10'h040, 10'h041, 10'h042, 10'h043, 10'h050, 10'h051, 10'h052, 10'h053};
    vecs[1].wr = '{10'h060, 10'h061, 10'h062, 10'h063};

    vecs[2].a_addr = 10'h3FE; vecs[2].b_addr = 10'h100; vecs[2].c_addr = 10'h3FF;
    vecs[2].a  = '{32'd1, 32'd2, 32'd3, 32'd4};
    vecs[2].b  = '{32'd5, 32'd6, 32'd7, 32'd8};
    vecs[2].c  = '{32'd19, 32'd22, 32'd43, 32'd50};
    vecs[2].rd = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h100, 10'h101, 10'h102, 10'h103};
    vecs[2].wr = '{10'h3FF, 10'h000, 10'h001, 10'h002};

    vecs[3].a_addr = 10'h080; vecs[3].b_addr = 10'h090; vecs[3].c_addr = 10'h0A0;
    vecs[3].a  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    vecs[3].b  = '{32'd2, 32'd2, 32'd2, 32'd2};
    vecs[3].c  = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC};
    vecs[3].rd = '{10'h080, 10'h081, 10'h082, 10'h083, 10'h090, 10'h091, 10'h092, 10'h093};
    vecs[3].wr = '{10'h0A0, 10'h0A1, 10'h0A2, 10'h0A3};

    rst_n     = 1'b0;
    en_npu    = 1'b0;
    matA_addr = '0;
    matB_addr = '0;
    matC_addr = '0;
    #23;
    check("reset_outputs", 64'({mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, busy, ack}), 64'd0);
    check("reset_wr_data", 64'(mem_wr_data), 64'd0);
    @(negedge clk_50);
    rst_n = 1'b1;
    @(negedge clk_50);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Abort in MAC right after the first C write has been issued.
    load_vec(1);
    quiet = 0;
    @(negedge clk_50);
    en_npu = 1'b1;
    for (int n = 1; n <= 16; n++) @(negedge clk_50);
    check("abort_first_wr_en", 64'(mem_wr_en), 64'd1);
    check("abort_first_wr_addr", 64'(mem_wr_addr), 64'h060);
    en_npu = 1'b0;
    @(negedge clk_50);
    check("abort_idle", 64'({busy, mem_wr_en, ack}), 64'd0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_50);
      if (mem_wr_en || ack || busy) quiet++;
    end
    check("abort_quiet", 64'(quiet), 64'd0);

    // Asynchronous reset in the middle of LOAD.
    load_vec(0);
    @(negedge clk_50);
    en_npu = 1'b1;
    for (int n = 1; n <= 8; n++) @(negedge clk_50);
    check("pre_reset_rd_en", 64'({busy, mem_rd_en}), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, busy, ack}), 64'd0);
    en_npu = 1'b0;
    @(negedge clk_50);
    @(negedge clk_50);
    rst_n = 1'b1;
    @(negedge clk_50);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
